// File: rtl/uart_rx_9600_if.sv
// Receive-side handshake bundle: held byte, ready/ack pair, error flags and FSM visibility.
interface uart_rx_9600_if;
   logic       rx_ack;
   logic [7:0] rx_data;
   logic       rx_ready;
   logic       frame_err;
   logic       overrun;
   logic       busy;
   logic [2:0] fsm_state;

   // rx_ready is a level: it stays high while a byte is held and drops the cycle after
   // rx_ack is seen high on a clock edge. An rx_ack seen while rx_ready is low does nothing.
   modport master (
      input  rx_ack,
      output rx_data, rx_ready, frame_err, overrun, busy, fsm_state
   );

   modport slave (
      output rx_ack,
      input  rx_data, rx_ready, frame_err, overrun, busy, fsm_state
   );
endinterface

// File: rtl/uart_rx_9600.sv
// 8N1 UART receiver clocked by the system clock with an internal baud counter,
// delivering bytes through a ready/ack holding register with framing and overrun flags.
module uart_rx_9600 #(
   parameter int CLK_HZ = 48000000,
   parameter int BAUD   = 9600
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            DATA_IN,
   uart_rx_9600_if.master  rx
);
   localparam int CLKS_PER_BIT = CLK_HZ / BAUD;
   localparam int HALF_BIT     = CLKS_PER_BIT / 2;
   localparam int CW           = $clog2(CLKS_PER_BIT);
   localparam logic [CW-1:0] HALF_LAST = CW'(HALF_BIT - 1);
   localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_START = 3'd1,
      S_DATA  = 3'd2,
      S_STOP  = 3'd3,
      S_BREAK = 3'd4
   } state_t;

   state_t        state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [2:0]    idx_q, idx_d;
   logic [7:0]    shift_q, shift_d;
   logic [7:0]    data_q, data_d;
   logic          ready_q, ready_d;
   logic          ferr_q, ferr_d;
   logic          ovr_q, ovr_d;
   logic [1:0]    sync_q;
   logic          rxs;

   assign rxs = sync_q[1];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         idx_q   <= '0;
         shift_q <= '0;
         data_q  <= '0;
         ready_q <= 1'b0;
         ferr_q  <= 1'b0;
         ovr_q   <= 1'b0;
         sync_q  <= 2'b11;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         idx_q   <= idx_d;
         shift_q <= shift_d;
         data_q  <= data_d;
         ready_q <= ready_d;
         ferr_q  <= ferr_d;
         ovr_q   <= ovr_d;
         sync_q  <= {sync_q[0], DATA_IN};
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      idx_d   = idx_q;
      shift_d = shift_q;
      data_d  = data_q;
      ready_d = ready_q;
      ferr_d  = ferr_q;
      ovr_d   = ovr_q;

      if (rx.rx_ack) begin
         ready_d = 1'b0;
         ovr_d   = 1'b0;
      end

      case (state_q)
         S_IDLE: begin
            if (!rxs) begin
               state_d = S_START;
               cnt_d   = '0;
            end
         end
         S_START: begin
            if (cnt_q == HALF_LAST) begin
               cnt_d = '0;
               idx_d = '0;
               state_d = rxs ? S_IDLE : S_DATA;
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         S_DATA: begin
            if (cnt_q == BIT_LAST) begin
               cnt_d          = '0;
               shift_d[idx_q] = rxs;
               idx_d          = idx_q + 3'd1;
               if (idx_q == 3'd7) state_d = S_STOP;
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         S_STOP: begin
            if (cnt_q == BIT_LAST) begin
               cnt_d = '0;
               if (rxs) begin
                  // An ack on the completing edge frees the slot, so no overrun then.
                  data_d  = shift_q;
                  ready_d = 1'b1;
                  ferr_d  = 1'b0;
                  if (ready_q && !rx.rx_ack) ovr_d = 1'b1;
                  state_d = S_IDLE;
               end else begin
                  ferr_d  = 1'b1;
                  state_d = S_BREAK;
               end
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         S_BREAK: begin
            if (rxs) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   assign rx.rx_data   = data_q;
   assign rx.rx_ready  = ready_q;
   assign rx.frame_err = ferr_q;
   assign rx.overrun   = ovr_q;
   assign rx.busy      = (state_q != S_IDLE);
   assign rx.fsm_state = state_q;
endmodule

// File: doc/uart_rx_9600.md
Name: uart_rx_9600

Overview:
- UART 8N1 serial receiver, the receive-side counterpart of the keypad-to-serial transmit path (9600 baud, LSB first, idle-high line).
- Runs directly on the 48 MHz board clock with an internal baud counter. No divided clock is used.
- Delivers received bytes through a ready/ack holding register, with framing-error and overrun flags.
- Feeds a downstream decoder, e.g. a seven-segment display or command logic.

Parameters:
- CLK_HZ, 48000000, system clock frequency in Hz.
- BAUD, 9600, serial bit rate.
- CLKS_PER_BIT, CLK_HZ/BAUD (5000), clock cycles per bit. Derived; must be ≥ 4.
- HALF_BIT, CLKS_PER_BIT/2 (2500), cycles from start edge to mid-start-bit sample.

Ports:
- clk  input  1  48 MHz system clock, rising-edge.
- rst  input  1  asynchronous active-high reset.
- DATA_IN  input  1  serial line, idle high, asynchronous to clk.
- rx_ack  input  1  consumer acknowledge; clears rx_ready and overrun.
- rx_data  output  8  last good received byte.
- rx_ready  output  1  level; high while an unacknowledged byte is held.
- frame_err  output  1  level; set on bad stop bit, cleared by next good frame.
- overrun  output  1  sticky; a byte completed while rx_ready was high without ack.
- busy  output  1  high whenever the FSM is not in IDLE.

Behaviour:
- Reset: a single clock and a single asynchronous active-high reset, rst, apply to all state.
- Reset values: rx_data=8'h00, rx_ready=0, frame_err=0, overrun=0, busy=0, FSM=IDLE, counters=0. Both synchronizer flops reset to 1 (idle level).
- Synchronizer: DATA_IN passes through a 2-flop synchronizer; all logic uses the synced value rxs. This adds 2 cycles of latency.
- States: IDLE, START, DATA, STOP, BREAK.
- IDLE: rxs==0 → START, with bit counter cnt=0.
- START: cnt increments each cycle. At cnt==HALF_BIT-1, sample rxs:
  - 0 → DATA, cnt=0, bit index=0.
  - 1 → IDLE (glitch rejected, nothing reported).
- DATA: at cnt==CLKS_PER_BIT-1, sample rxs into shift[index] (LSB first), cnt=0. After index 7 is sampled → STOP.
- STOP: at cnt==CLKS_PER_BIT-1, sample rxs:
  - 1 → load rx_data=shift, rx_ready=1, frame_err=0, go to IDLE.
  - 0 → frame_err=1; rx_data and rx_ready unchanged; go to BREAK.
- BREAK: wait until rxs==1, then IDLE. A held-low line never produces further frames.
- Sample points: every sample lands mid-bit. rx_ready rises 3 + HALF_BIT-1 + 9*CLKS_PER_BIT cycles (±1) after the DATA_IN falling edge, i.e. ≈9.5 bit times.
- rx_ack (sampled on a clock edge):
  - Next cycle rx_ready=0 and overrun=0.
  - Ack while rx_ready=0 has no effect.
- Simultaneous good-frame completion and rx_ack: new byte loaded, rx_ready stays 1, overrun not set.
- Good frame completion with rx_ready=1 and no ack: rx_data is overwritten with the new byte and overrun=1.
- frame_err does not affect rx_ready or overrun.
- Back-to-back frames: the next start bit is detected in IDLE, which is entered at mid-stop. There is no dead time beyond half a stop bit.
- Reset mid-frame: immediate return to reset values. The partial byte is discarded. After reset, the first falling edge is treated as a new start bit.
- Counters: sized to hold CLKS_PER_BIT-1, with no wrap inside a bit period. The bit index is 3 bits.

Test Plan:
- Reset, then send 0x35 at 9600 (bit = 5000 clk) → rx_data=0x35, rx_ready=1 at ≈47,500 cycles after the start edge; frame_err=0, overrun=0; busy high during the frame.
- Low pulse of 1000 cycles on the idle line → FSM returns to IDLE at sample, rx_ready stays 0, rx_data unchanged, busy falls after HALF_BIT.
- Frame 0xA5 with stop bit held 0, then line high → frame_err=1, rx_ready=0, rx_data keeps the previous value. Following good 0x0F → rx_data=0x0F, frame_err=0.
- Send 0x31 then 0x32 back to back, no ack → rx_data=0x32, rx_ready=1, overrun=1. Pulse rx_ack one cycle → both clear next cycle.
- rx_ack asserted on the exact cycle 0x7E completes while 0x41 is held → rx_data=0x7E, rx_ready=1, overrun=0.
- Assert rst during data bit 4 of 0xFF, release, then send 0x00 → only 0x00 is reported, rx_ready=1, all flags 0.
